// File: rtl/mmio_pkg.sv
// mmio_pkg: shared MMIO command codes, register addresses and debounce default
package mmio_pkg;
  typedef enum logic [1:0] {MNONE, MREAD, MWRITE} mcmd_t;
  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR = 9'h140;
  localparam logic [8:0] SW_EVT_ADDR = 9'h141;
  localparam int DEBOUNCE_DEFAULT = 50000;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one switch channel with synchronizer, stability counter, edge pulses and sticky flag
module debounce_bit
  import mmio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  input  logic evt_clr,
  output logic sw_stable,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_evt
);
  logic s1, s2, acc;
  logic [CNT_W-1:0] cnt;
  assign acc = (s2 != sw_stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      sw_stable <= 1'b0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      sw_evt <= 1'b0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
      cnt <= (s2 == sw_stable || acc) ? '0 : cnt + CNT_W'(1);
      sw_stable <= acc ? s2 : sw_stable;
      sw_rise <= acc & s2;
      sw_fall <= acc & ~s2;
      sw_evt <= (sw_evt & ~evt_clr) | acc;
    end
  end
endmodule

// File: rtl/mmio_switch_debounce.sv
// mmio_switch_debounce: debounces raw board switches for the MMIO SW input with edge and event flags
module mmio_switch_debounce
  import mmio_pkg::*;
#(
  parameter int N_SW = 10,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_raw,
  input  logic [N_SW-1:0] evt_clr,
  output logic [N_SW-1:0] sw_stable,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic [N_SW-1:0] sw_evt,
  output logic            any_evt
);
  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .reset(reset),
      .sw_raw(sw_raw[i]),
      .evt_clr(evt_clr[i]),
      .sw_stable(sw_stable[i]),
      .sw_rise(sw_rise[i]),
      .sw_fall(sw_fall[i]),
      .sw_evt(sw_evt[i])
    );
  end
  assign any_evt = |sw_evt;
endmodule

// File: tb/tb_mmio_switch_debounce.sv
// tb_mmio_switch_debounce: directed checks of debounce latency, glitch rejection, pulses and sticky flags
module tb_mmio_switch_debounce;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] sw_raw = '0;
  logic [9:0] evt_clr = '0;
  logic [9:0] sw_stable, sw_rise, sw_fall, sw_evt;
  logic any_evt;
  int checks = 0;
  int errors = 0;

  mmio_switch_debounce #(.N_SW(10), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .sw_raw(sw_raw),
    .evt_clr(evt_clr),
    .sw_stable(sw_stable),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_evt(sw_evt),
    .any_evt(any_evt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [9:0] st, input logic [9:0] ri,
                         input logic [9:0] fa, input logic [9:0] ev);
    chk({tag, ".stable"}, sw_stable, st);
    chk({tag, ".rise"}, sw_rise, ri);
    chk({tag, ".fall"}, sw_fall, fa);
    chk({tag, ".evt"}, sw_evt, ev);
    chk({tag, ".any"}, {9'b0, any_evt}, {9'b0, |ev});
  endtask

  task automatic clean_reset();
    sw_raw = '0;
    evt_clr = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk_all("clean_reset", '0, '0, '0, '0);
  endtask

  initial begin
    // 1: switches held high through reset re-qualify afterwards
    sw_raw = 10'h3FF;
    tick();
    chk_all("rst_c1", '0, '0, '0, '0);
    tick();
    chk_all("rst_c2", '0, '0, '0, '0);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("rst_wait", '0, '0, '0, '0);
    end
    tick();
    chk_all("rst_e6", 10'h3FF, 10'h3FF, '0, 10'h3FF);
    tick();
    chk_all("rst_e7", 10'h3FF, '0, '0, 10'h3FF);
    clean_reset();
    // 2: clean rising edge on bit 0
    sw_raw[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("clean_wait", '0, '0, '0, '0);
    end
    tick();
    chk_all("clean_e6", 10'h001, 10'h001, '0, 10'h001);
    tick();
    chk_all("clean_e7", 10'h001, '0, '0, 10'h001);
    evt_clr = 10'h001;
    tick();
    evt_clr = '0;
    chk_all("clean_clr", 10'h001, '0, '0, '0);
    // 3: three-cycle glitch on bit 3 is one short of acceptance
    sw_raw[3] = 1'b1;
    tick();
    chk_all("glitch_h1", 10'h001, '0, '0, '0);
    tick();
    chk_all("glitch_h2", 10'h001, '0, '0, '0);
    tick();
    chk_all("glitch_h3", 10'h001, '0, '0, '0);
    sw_raw[3] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_all("glitch_low", 10'h001, '0, '0, '0);
    end
    // 4: bouncing bit 5 then settling high
    for (int k = 0; k < 4; k++) begin
      sw_raw[5] = (k % 2 == 0);
      tick();
      chk_all("bounce_tog", 10'h001, '0, '0, '0);
    end
    sw_raw[5] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("bounce_wait", 10'h001, '0, '0, '0);
    end
    tick();
    chk_all("bounce_e6", 10'h021, 10'h020, '0, 10'h020);
    tick();
    chk_all("bounce_e7", 10'h021, '0, '0, 10'h020);
    evt_clr = 10'h020;
    tick();
    evt_clr = '0;
    chk_all("bounce_clr", 10'h021, '0, '0, '0);
    // 5: clear colliding with a new event loses to the set
    sw_raw[2] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("coll_wait", 10'h021, '0, '0, '0);
    end
    evt_clr = 10'h004;
    tick();
    evt_clr = '0;
    chk_all("coll_e6", 10'h025, 10'h004, '0, 10'h004);
    tick();
    chk_all("coll_hold", 10'h025, '0, '0, 10'h004);
    evt_clr = 10'h004;
    tick();
    evt_clr = '0;
    chk_all("coll_clr", 10'h025, '0, '0, '0);
    // 6: reset on edge 4 discards the partial count on bit 7
    clean_reset();
    sw_raw = 10'h080;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_all("midrst_pre", '0, '0, '0, '0);
    end
    reset = 1'b1;
    tick();
    chk_all("midrst_r1", '0, '0, '0, '0);
    tick();
    chk_all("midrst_r2", '0, '0, '0, '0);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("midrst_wait", '0, '0, '0, '0);
    end
    tick();
    chk_all("midrst_e6", 10'h080, 10'h080, '0, 10'h080);
    // falling edge on bit 7 with pending flag still set
    sw_raw = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("fall_wait", 10'h080, '0, '0, 10'h080);
    end
    tick();
    chk_all("fall_e6", '0, '0, 10'h080, 10'h080);
    tick();
    chk_all("fall_e7", '0, '0, '0, 10'h080);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
